// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/busy/done operand and product bundle for seq_multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-add multiplier, one partial product per clock
// Optional: SEQ_MULTIPLIER_EARLY_TERM_EN ends the operation once no multiplier bits remain.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mult;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc_next;
    logic [WIDTH-1:0] mult_next;
    logic            last;
    logic            busy_r;
    logic            done_r;
    logic [PW-1:0]   p_r;

    always_comb begin
        acc_next  = acc + (mult[0] ? mcand : '0);
        mult_next = mult >> 1;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        last      = (cnt == LAST_ITER) || (mult_next == '0);
`else
        last      = (cnt == LAST_ITER);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mult   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            p_r    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
                        mcand <= PW'(bus.A);
                        mult  <= bus.B;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
                        // A zero operand cannot contribute anything, so skip the iterations.
                        if (bus.A == '0 || bus.B == '0) begin
                            p_r    <= '0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= CALC;
                        end
`else
                        busy_r <= 1'b1;
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mult  <= mult_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        p_r    <= acc_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.P    = p_r;
endmodule
